// File: rtl/framebuffer_arbiter_if.sv
// Bundle of writer, reader, swap-control and RAM signals around the frame-buffer arbiter.
// The arbiter uses the slave modport; the surrounding system drives the master side.
interface framebuffer_arbiter_if #(
    parameter int AddrWidth = 13,
    parameter int DataWidth = 16
);
    logic                 wr_valid;
    logic                 wr_ready;
    logic [AddrWidth-1:0] wr_addr;
    logic [DataWidth-1:0] wr_data;
    logic                 swap_req;
    logic                 swap_pending;
    logic                 front_bank;
    logic                 frame_begin;
    logic                 rd_req;
    logic [AddrWidth-1:0] rd_addr;
    logic                 rd_valid;
    logic [DataWidth-1:0] rd_data;
    logic [AddrWidth:0]   mem_addr;
    logic                 mem_we;
    logic [DataWidth-1:0] mem_wdata;
    logic [DataWidth-1:0] mem_rdata;

    modport slave (
        input  wr_valid, wr_addr, wr_data, swap_req, frame_begin, rd_req, rd_addr, mem_rdata,
        output wr_ready, swap_pending, front_bank, rd_valid, rd_data, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output wr_valid, wr_addr, wr_data, swap_req, frame_begin, rd_req, rd_addr, mem_rdata,
        input  wr_ready, swap_pending, front_bank, rd_valid, rd_data, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/framebuffer_arbiter.sv
// Single-port pixel RAM controller: double-buffered banks, read-priority arbitration,
// small write FIFO and frame-aligned bank swapping.
module framebuffer_arbiter #(
    parameter int AddrWidth = 13,
    parameter int DataWidth = 16,
    parameter int FifoDepth = 4
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    framebuffer_arbiter_if.slave bus
);
    localparam int IdxW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int PtrW = IdxW + 1;

    typedef enum logic [0:0] {
        SW_IDLE = 1'b0,
        SW_PEND = 1'b1
    } swap_state_e;

    swap_state_e          r_swap_state;
    swap_state_e          w_swap_next;
    logic                 r_front_bank;
    logic                 w_front_next;

    logic                 r_fifo_bank [FifoDepth];
    logic [AddrWidth-1:0] r_fifo_addr [FifoDepth];
    logic [DataWidth-1:0] r_fifo_data [FifoDepth];
    logic [PtrW-1:0]      r_wr_ptr;
    logic [PtrW-1:0]      r_rd_ptr;
    logic [PtrW-1:0]      w_count;
    logic [IdxW-1:0]      w_head_idx;
    logic [IdxW-1:0]      w_tail_idx;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr_ready;
    logic                 w_push;
    logic                 w_pop;

    logic [AddrWidth:0]   r_mem_addr_p0;
    logic                 r_mem_we_p0;
    logic [DataWidth-1:0] r_mem_wdata_p0;
    logic                 r_rd_vld_p0;
    logic                 r_rd_vld_p1;
    logic                 r_rd_vld_p2;
    logic [DataWidth-1:0] r_rd_data_p2;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_count == PtrW'(FifoDepth));
    assign w_empty    = (w_count == '0);
    assign w_head_idx = r_rd_ptr[IdxW-1:0];
    assign w_tail_idx = r_wr_ptr[IdxW-1:0];
    assign w_wr_ready = !w_full && (r_swap_state == SW_IDLE);
    assign w_push     = bus.wr_valid && w_wr_ready;
    assign w_pop      = !bus.rd_req && !w_empty;

    always_comb begin
        w_swap_next  = r_swap_state;
        w_front_next = r_front_bank;
        case (r_swap_state)
            SW_IDLE: begin
                if (bus.swap_req) begin
                    w_swap_next = SW_PEND;
                end
            end
            SW_PEND: begin
                if (bus.frame_begin && w_empty) begin
                    w_swap_next  = SW_IDLE;
                    w_front_next = ~r_front_bank;
                end
            end
            default: w_swap_next = SW_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_swap_state <= SW_IDLE;
            r_front_bank <= 1'b0;
        end else begin
            r_swap_state <= w_swap_next;
            r_front_bank <= w_front_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
        end
    end

    // Entries are tagged with the back bank at accept time.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_bank[w_tail_idx] <= ~r_front_bank;
            r_fifo_addr[w_tail_idx] <= bus.wr_addr;
            r_fifo_data[w_tail_idx] <= bus.wr_data;
        end
    end

    // Stage p0: arbitration result registered onto the RAM port.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_mem_addr_p0  <= '0;
            r_mem_we_p0    <= 1'b0;
            r_mem_wdata_p0 <= '0;
        end else if (bus.rd_req) begin
            r_mem_addr_p0  <= {r_front_bank, bus.rd_addr};
            r_mem_we_p0    <= 1'b0;
        end else if (w_pop) begin
            r_mem_addr_p0  <= {r_fifo_bank[w_head_idx], r_fifo_addr[w_head_idx]};
            r_mem_we_p0    <= 1'b1;
            r_mem_wdata_p0 <= r_fifo_data[w_head_idx];
        end else begin
            r_mem_we_p0    <= 1'b0;
        end
    end

    // Stages p0..p2: read tag follows the address, the RAM cycle, then the capture.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_rd_vld_p0  <= 1'b0;
            r_rd_vld_p1  <= 1'b0;
            r_rd_vld_p2  <= 1'b0;
            r_rd_data_p2 <= '0;
        end else begin
            r_rd_vld_p0 <= bus.rd_req;
            r_rd_vld_p1 <= r_rd_vld_p0;
            r_rd_vld_p2 <= r_rd_vld_p1;
            if (r_rd_vld_p1) begin
                r_rd_data_p2 <= bus.mem_rdata;
            end
        end
    end

    assign bus.wr_ready     = w_wr_ready;
    assign bus.swap_pending = (r_swap_state == SW_PEND);
    assign bus.front_bank   = r_front_bank;
    assign bus.mem_addr     = r_mem_addr_p0;
    assign bus.mem_we       = r_mem_we_p0;
    assign bus.mem_wdata    = r_mem_wdata_p0;
    assign bus.rd_valid     = r_rd_vld_p2;
    assign bus.rd_data      = r_rd_data_p2;
endmodule

// File: doc/framebuffer_arbiter.md
# framebuffer_arbiter

Controller for the single-port pixel RAM between the SPI write path and the display read path. It double-buffers the 128x64 RGB565 frame store across two 8192-word banks and gives display reads strict priority, buffering SPI writes in a small FIFO. It swaps front and back banks only on a frame boundary. It sits between spi_ram_slave (writer), ram_source (reader) and one 16384x16 synchronous-read RAM.

## Interface
- AddrWidth, 13, pixel address width per bank (8192 pixels)
- DataWidth, 16, pixel width (RGB565)
- FifoDepth, 4, write FIFO entries; power of two, at least 2

- clk  in  1  system clock (50 MHz domain); all logic on posedge
- resetn  in  1  one clock; reset is asynchronous and active-low
- wr_valid  in  1  writer presents a pixel write
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_addr  in  AddrWidth  pixel index of the write
- wr_data  in  DataWidth  pixel value
- swap_req  in  1  single-cycle pulse: back bank complete, request swap
- swap_pending  out  1  swap requested, not yet executed
- front_bank  out  1  bank currently displayed
- frame_begin  in  1  single-cycle pulse from reader at frame start
- rd_req  in  1  reader requests one pixel
- rd_addr  in  AddrWidth  pixel index to read
- rd_valid  out  1  rd_data holds the result of a read
- rd_data  out  DataWidth  read pixel
- mem_addr  out  AddrWidth+1  {bank, pixel index}, registered
- mem_we  out  1  registered write strobe
- mem_wdata  out  DataWidth  registered write data
- mem_rdata  in  DataWidth  RAM read data, valid one cycle after the address

## Operation
- Write FIFO stores {bank, addr, data}, FifoDepth entries.
  - On push, bank = ~front_bank, tagged at accept time.
  - wr_ready = !fifo_full && !swap_pending. This blocks writes into a bank that is about to become front.
- Per-cycle arbitration (stage A, registered into mem_*):
  - rd_req=1: mem_addr={front_bank, rd_addr}, mem_we=0. A read tag is pushed into the 2-deep read pipeline.
  - rd_req=0 and FIFO non-empty: pop head, mem_addr={tag bank, addr}, mem_wdata=data, mem_we=1.
  - Otherwise mem_we=0. mem_addr holds its last value.
- A simultaneous push and pop on a full FIFO is legal; wr_ready already reflects fullness before the pop.
- Swap control:
  - swap_req with swap_pending=0 sets swap_pending. swap_req while pending is ignored.
  - On a frame_begin cycle with swap_pending=1 and the FIFO empty: front_bank toggles and swap_pending clears at the next edge.
  - With the FIFO non-empty, the swap waits for a later frame_begin.
  - swap_req and frame_begin in the same cycle: pending is set, and the swap happens no earlier than the next frame_begin.
- Reads sampled in the frame_begin cycle use the old front_bank. Reads from the following cycle use the new one.
- Writes are never reordered. Reads and writes to the same location in different banks are independent.

## Timing
- Values held during reset (resetn=0):
  - front_bank=0, swap_pending=0, FIFO empty, wr_ready=1
  - mem_we=0, mem_addr=0, mem_wdata=0
  - rd_valid=0, rd_data=0
- Read latency is 3 cycles:
  - rd_req sampled at edge N
  - mem_addr driven after N
  - mem_rdata captured at N+2
  - rd_valid=1 and rd_data valid after N+2, for exactly one cycle per request
- Back-to-back reads give back-to-back rd_valid, one result per cycle, in order.
- Write acceptance to mem_we is at least 1 cycle. Reads take priority, so a write may wait indefinitely under continuous rd_req. The reader's blanking gaps bound the wait.
- front_bank changes 1 cycle after the qualifying frame_begin.
- Asserting resetn low mid-operation:
  - discards FIFO contents and pending swap
  - drops in-flight reads, so no rd_valid follows
  - forces mem_we low asynchronously
- wr_ready is combinational from FIFO count and swap_pending only, with no input-to-output path.

## Test plan
- Reset, then write pixel 0x0005=0xF800 with no reads:
  - mem_we=1 with mem_addr=0x2005, mem_wdata=0xF800 (back bank 1)
  - wr_ready stays 1
- Hold rd_req continuously while pushing 5 writes:
  - wr_ready drops after 4 accepted writes
  - no mem_we while rd_req=1
  - on rd_req release, 4 writes issue in order on consecutive cycles
- Read addr 0x0010 with mem_rdata=0x07E0 returned:
  - rd_valid exactly 3 cycles after rd_req, rd_data=0x07E0
  - mem_addr=0x0010 (front bank 0)
- swap_req with the FIFO empty, frame_begin 10 cycles later:
  - swap_pending=1 and wr_ready=0 during the gap
  - front_bank=1 one cycle after frame_begin, swap_pending=0
  - the next read of addr 0x0010 drives mem_addr=0x2010
- swap_req with 2 writes queued under continuous reads, frame_begin mid-stall:
  - no swap at that frame_begin
  - swap at the first frame_begin after the FIFO drains
  - queued writes land in bank 1
- Assert resetn low with 3 FIFO entries and 2 reads in flight:
  - no further mem_we or rd_valid
  - all outputs at reset values
  - front_bank=0
